// File: rtl/ysyx_23060171_pkg.sv
// Shared types and constants for the ysyx_23060171 core front end.
package ysyx_23060171_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } ifu_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

endpackage

// File: rtl/ysyx_23060171_npc_sel.sv
// Next-PC priority mux: interrupt, then mret, then redirect, then sequential.
module ysyx_23060171_npc_sel (
    input  logic [31:0] pc_i,
    input  logic        irq_i,
    input  logic        mret_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic [31:0] npc_o,
    output logic        misalign_o
);

    logic [31:0] raw_pc;

    always_comb begin
        raw_pc = pc_i + 32'd4;
        if (irq_i) begin
            raw_pc = mtvec_i;
        end else if (mret_i) begin
            raw_pc = mepc_i;
        end else if (redirect_i) begin
            raw_pc = redirect_pc_i;
        end
    end

    // Fetches are always word aligned; low bits are dropped and flagged.
    assign npc_o      = {raw_pc[31:2], 2'b00};
    assign misalign_o = |raw_pc[1:0];

endmodule

// File: rtl/ysyx_23060171_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word per retirement over valid/ready.
module ysyx_23060171_ifu
    import ysyx_23060171_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    input  logic        resp_err,
    output logic [31:0] inst,
    output logic [31:0] pcD,
    output logic [31:0] pc_plus_4D,
    output logic        inst_valid,
    output logic        fetch_err,
    input  logic        commit,
    input  logic        irqF,
    input  logic        mret,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        misalign
);

    ifu_state_t  state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus_4_q;
    logic [31:0] inst_q;
    logic        req_valid_q;
    logic        inst_valid_q;
    logic        fetch_err_q;
    logic        misalign_q;

    logic [31:0] npc;
    logic        npc_misalign;

    ysyx_23060171_npc_sel u_npc_sel (
        .pc_i          (pc_q),
        .irq_i         (irqF),
        .mret_i        (mret),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .mtvec_i       (mtvec),
        .mepc_i        (mepc),
        .npc_o         (npc),
        .misalign_o    (npc_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pc_plus_4_q  <= RESET_PC + 32'd4;
            inst_q       <= NOP_INST;
            req_valid_q  <= 1'b1;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            unique case (state_q)
                FETCH: begin
                    if (req_valid_q && req_ready) begin
                        state_q     <= WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (resp_valid) begin
                        state_q      <= HOLD;
                        inst_q       <= resp_err ? NOP_INST : resp_data;
                        fetch_err_q  <= resp_err;
                        inst_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    // Next-PC controls are only meaningful on retirement.
                    if (commit) begin
                        state_q      <= FETCH;
                        pc_q         <= npc;
                        pc_plus_4_q  <= npc + 32'd4;
                        misalign_q   <= npc_misalign;
                        inst_valid_q <= 1'b0;
                        fetch_err_q  <= 1'b0;
                        req_valid_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= FETCH;
                    req_valid_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_valid  = req_valid_q;
    assign req_addr   = pc_q;
    assign inst       = inst_q;
    assign pcD        = pc_q;
    assign pc_plus_4D = pc_plus_4_q;
    assign inst_valid = inst_valid_q;
    assign fetch_err  = fetch_err_q;
    assign misalign   = misalign_q;

endmodule

// File: doc/ysyx_23060171_ifu.md
# ysyx_23060171_ifu

Instruction fetch unit for the multi-cycle core. It holds the architectural PC, fetches one instruction per retirement over a valid/ready memory port, and presents `inst`, `pcD` and `pc_plus_4D` to the decode stage. It then chooses the next PC from the sequential value, a control-transfer target, `mtvec` on interrupt, or `mepc` on `mret`.

## Interface
Parameters:
- `RESET_PC`, `32'h8000_0000`: PC loaded on reset.
- `NOP_INST`, `32'h0000_0013`: instruction substituted when a fetch returns an error.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  out  1  fetch request valid
- `req_ready`  in  1  memory accepts request
- `req_addr`  out  32  fetch address (word aligned)
- `resp_valid`  in  1  fetch data valid (single-cycle pulse)
- `resp_data`  in  32  fetched word
- `resp_err`  in  1  access fault on this response
- `inst`  out  32  instruction to decode
- `pcD`  out  32  PC of `inst`
- `pc_plus_4D`  out  32  `pcD + 4`
- `inst_valid`  out  1  `inst`/`pcD` valid, held until commit
- `fetch_err`  out  1  `inst` is `NOP_INST` due to `resp_err`
- `commit`  in  1  current instruction retired; sample next-PC controls
- `irqF`  in  1  take interrupt, next PC = `mtvec`
- `mret`  in  1  return from trap, next PC = `mepc`
- `redirect`  in  1  taken jump/branch, next PC = `redirect_pc`
- `redirect_pc`  in  32  jump/branch target
- `mtvec`  in  32  trap vector
- `mepc`  in  32  trap return address
- `misalign`  out  1  one-cycle pulse: selected next PC had `[1:0] != 0`

## Operation
- States:
  - `FETCH`: `req_valid=1`, `req_addr=pc`.
  - `WAIT`: request accepted, awaiting `resp_valid`.
  - `HOLD`: `inst_valid=1`, awaiting `commit`.
- `FETCH`→`WAIT` on `req_valid & req_ready`.
- `WAIT`→`HOLD` on `resp_valid`:
  - latch `inst = resp_err ? NOP_INST : resp_data`.
  - `fetch_err = resp_err`.
- `HOLD`→`FETCH` on `commit`. PC loads next PC in that cycle.
- Next-PC priority, evaluated only on `commit` in `HOLD`:
  1. `irqF` → `mtvec`
  2. `mret` → `mepc`
  3. `redirect` → `redirect_pc`
  4. otherwise → `pc + 4`
- Selected next PC has bits `[1:0]` forced to 0. `misalign` pulses if they were nonzero.
- `pc + 4` wraps modulo 2^32; `32'hFFFF_FFFC` → `32'h0000_0000`.
- `req_addr` stays stable while `req_valid=1` and `req_ready=0`.
- `commit` outside `HOLD` is ignored.
- `resp_valid` outside `WAIT` is ignored.
- `resp_valid` in the same cycle as acceptance is not possible; minimum memory latency is 1 cycle.
- Reset values:
  - pc = `RESET_PC`, state `FETCH`
  - `req_valid=1` once `rst_n` high
  - `inst=NOP_INST`, `pcD=RESET_PC`, `pc_plus_4D=RESET_PC+4`
  - `inst_valid=0`, `fetch_err=0`, `misalign=0`
- Reset mid-operation (any state): immediately returns to reset values. An outstanding response arriving after reset release is dropped, because state is `FETCH`, not `WAIT`.

## Timing
- `pcD`/`pc_plus_4D` are registered and change only on commit-driven PC update. They are constant throughout `HOLD`.
- Fetch latency, `commit` to `inst_valid`: 1 cycle (`FETCH`) + handshake wait + memory latency + 1 cycle (latch).
- With `req_ready=1` and 1-cycle memory: `commit` at cycle N → `req_valid` at N+1 → `resp_valid` at N+2 → `inst_valid` at N+3.
- `inst_valid` drops the cycle after `commit`.
- `misalign` is asserted in the cycle after `commit`.

## Structure
- Shared package `ysyx_23060171_pkg`:
  - `ifu_state_t` enum (`FETCH`, `WAIT`, `HOLD`)
  - `RESET_PC_DEF`, `NOP_INST_DEF` constants
- Sub-module `ysyx_23060171_npc_sel`: combinational priority mux of `irqF`/`mret`/`redirect`/sequential → next PC plus misalign flag. Kept separate so EXU-side changes do not touch the FSM.

## Test plan
- Reset release, `req_ready=1`, 1-cycle memory returning `32'h0010_0093` → `req_addr=32'h8000_0000`, then `inst=32'h0010_0093`, `pcD=32'h8000_0000`, `pc_plus_4D=32'h8000_0004`, `inst_valid` held until `commit`.
- `req_ready` low 3 cycles → `req_addr` stable, no state advance; fetch completes after ready rises.
- `commit` with `irqF=1`, `mret=1`, `redirect=1` together, `mtvec=32'h8000_0100` → next `req_addr=32'h8000_0100`.
- `commit` with `redirect=1`, `redirect_pc=32'h8000_0022` → `misalign` pulse, `req_addr=32'h8000_0020`.
- `resp_err=1` → `inst=32'h0000_0013`, `fetch_err=1`; cleared on next fetch.
- `rst_n` low during `WAIT`, late `resp_valid` after release → ignored; fetch restarts at `32'h8000_0000`.
